// File: rtl/ps2_pkg.sv
// PS/2 Set-2 transmit path: shared constants, event type and FSM states.
// Byte-selection helpers keep the sequencing rules in one place.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam logic [8:0] PS2_CODE_NONE    = 9'h000;

  typedef struct packed {
    logic       make;
    logic [8:0] code;
  } ps2_evt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_E0,
    ST_SEND_F0,
    ST_SEND_CODE,
    ST_GAP
  } ps2_tx_state_t;

  function automatic logic ps2_is_send(input ps2_tx_state_t s);
    return (s == ST_SEND_E0) || (s == ST_SEND_F0) ||
           (s == ST_SEND_CODE);
  endfunction

  function automatic ps2_tx_state_t ps2_first(input ps2_evt_t e);
    if (e.code[8])
      return ST_SEND_E0;
    else if (!e.make)
      return ST_SEND_F0;
    else
      return ST_SEND_CODE;
  endfunction

  function automatic ps2_tx_state_t ps2_after(
    input ps2_tx_state_t s,
    input logic          make
  );
    case (s)
      ST_SEND_E0: return make ? ST_SEND_CODE : ST_SEND_F0;
      ST_SEND_F0: return ST_SEND_CODE;
      default:    return ST_IDLE;
    endcase
  endfunction

  function automatic logic [7:0] ps2_byte(
    input ps2_tx_state_t s,
    input logic [8:0]    code
  );
    case (s)
      ST_SEND_E0:   return PS2_PREFIX_EXT;
      ST_SEND_F0:   return PS2_PREFIX_BREAK;
      ST_SEND_CODE: return code[7:0];
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead FIFO of key events.
// Push is refused when full; pop is refused when empty.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push,
  input  logic     pop,
  input  ps2_evt_t din,
  output ps2_evt_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ps2_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_scancode_tx.sv
// Key-event to PS/2 Set-2 byte stream serializer.
// Emits optional E0, optional F0, then the base code, one byte per handshake.
module ps2_scancode_tx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       evt_valid,
  output logic       evt_ready,
  input  logic [8:0] evt_code,
  input  logic       evt_make,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_last,
  output logic       busy,
  output logic       overflow
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  ps2_tx_state_t state;
  ps2_tx_state_t pend;
  ps2_tx_state_t nxt;
  ps2_evt_t      hold;
  ps2_evt_t      evt;
  ps2_evt_t      fifo_dout;
  logic          held;
  logic          leave;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [GW-1:0] gap_cnt;

  assign evt       = '{make: evt_make, code: evt_code};
  assign evt_ready = !full;
  assign push      = evt_valid && !full && (evt_code != PS2_CODE_NONE);
  assign pop       = (state == ST_IDLE) && !held && !empty;
  assign busy      = !empty || held || (state != ST_IDLE);

  ps2_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .din    (evt),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty)
  );

  // Target of the current state once it is allowed to move on.
  always_comb begin
    nxt   = ST_IDLE;
    leave = 1'b0;
    unique case (state)
      ST_IDLE: begin
        nxt   = ps2_first(hold);
        leave = held;
      end
      ST_SEND_E0, ST_SEND_F0, ST_SEND_CODE: begin
        nxt   = ps2_after(state, hold.make);
        leave = tx_ready;
      end
      ST_GAP: begin
        nxt   = pend;
        leave = (gap_cnt == GW'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      pend     <= ST_IDLE;
      hold     <= '0;
      held     <= 1'b0;
      gap_cnt  <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_last  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= evt_valid && full;
      if (pop) begin
        hold <= fifo_dout;
        held <= 1'b1;
      end
      if ((state == ST_GAP) && !leave)
        gap_cnt <= gap_cnt - GW'(1);
      if (leave) begin
        if (state == ST_IDLE)
          held <= 1'b0;
        // Every accepted byte is followed by the idle gap, if any.
        if (ps2_is_send(state) && (GAP_CYCLES > 0)) begin
          state    <= ST_GAP;
          pend     <= nxt;
          gap_cnt  <= GW'(GAP_CYCLES);
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
        end else begin
          state    <= nxt;
          tx_valid <= ps2_is_send(nxt);
          tx_data  <= ps2_byte(nxt, hold.code);
          tx_last  <= (nxt == ST_SEND_CODE);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_tx.sv
// Self-checking bench for ps2_scancode_tx.
// Expected byte streams come from a per-event expansion model.
module tb_ps2_scancode_tx;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       evt_valid, evt_make, tx_ready;
  logic [8:0] evt_code;
  logic       evt_ready, tx_valid, tx_last, busy, overflow;
  logic [7:0] tx_data;

  logic       g_evt_valid, g_evt_make, g_tx_ready;
  logic [8:0] g_evt_code;
  logic       g_evt_ready, g_tx_valid, g_tx_last, g_busy, g_overflow;
  logic [7:0] g_tx_data;

  int checks = 0;
  int fails  = 0;

  logic [8:0] expq[$];
  logic [8:0] gotq[$];

  logic       s_valid, s_ready, s_last, s_evr, s_ovf, s_busy;
  logic [7:0] s_data;
  logic       gs_valid, gs_last, gs_busy;
  logic [7:0] gs_data;

  ps2_scancode_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_make(evt_make),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last),
    .busy(busy), .overflow(overflow)
  );

  ps2_scancode_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(3)) dut_g (
    .clk(clk), .reset_n(reset_n),
    .evt_valid(g_evt_valid), .evt_ready(g_evt_ready),
    .evt_code(g_evt_code), .evt_make(g_evt_make),
    .tx_valid(g_tx_valid), .tx_ready(g_tx_ready),
    .tx_data(g_tx_data), .tx_last(g_tx_last),
    .busy(g_busy), .overflow(g_overflow)
  );

  // Reference: one key event expands to its Set-2 byte sequence.
  function automatic void model_event(input logic [8:0] code,
                                      input logic make);
    if (code == 9'h000) return;
    if (code[8]) expq.push_back({1'b0, 8'hE0});
    if (!make) expq.push_back({1'b0, 8'hF0});
    expq.push_back({1'b1, code[7:0]});
  endfunction

  task automatic tick();
    @(negedge clk);
    s_valid = tx_valid; s_ready = tx_ready; s_data = tx_data;
    s_last = tx_last; s_evr = evt_ready; s_ovf = overflow;
    s_busy = busy;
    gs_valid = g_tx_valid; gs_data = g_tx_data;
    gs_last = g_tx_last; gs_busy = g_busy;
    if (evt_valid && evt_ready) model_event(evt_code, evt_make);
    if (tx_valid && tx_ready) gotq.push_back({tx_last, tx_data});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit ok);
    evt_valid = 1'b0;
    tx_ready  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!s_busy && !s_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if (evt_ready !== 1'b1) begin
      fails++; $display("FAIL reset_evt_ready: got %b want 1", evt_ready);
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
    end
    checks++;
    if (tx_data !== 8'h00) begin
      fails++; $display("FAIL reset_tx_data: got %h want 00", tx_data);
    end
    checks++;
    if (tx_last !== 1'b0) begin
      fails++; $display("FAIL reset_tx_last: got %b want 0", tx_last);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL reset_overflow: got %b want 0", overflow);
    end
    checks++;
    if (g_tx_valid !== 1'b0 || g_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_gap_dut: got valid=%b busy=%b want 0/0",
               g_tx_valid, g_busy);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_make();
    int first;
    bit ok;
    expq.delete(); gotq.delete();
    tx_ready = 1'b1;
    evt_code = 9'h01C; evt_make = 1'b1; evt_valid = 1'b1;
    tick();
    evt_valid = 1'b0;
    first = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (s_valid && first < 0) first = i;
    end
    checks++;
    if (first != 3) begin
      fails++;
      $display("FAIL single_latency: got %0d cycles want 3", first);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL single_drain: timeout, busy=%b", s_busy);
    end
    checks++;
    if (gotq.size() != expq.size()) begin
      fails++;
      $display("FAIL single_count: got %0d bytes want %0d",
               gotq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        fails++;
        $display("FAIL single_byte%0d: got %h want %h", i, gotq[i], expq[i]);
      end
    end
  endtask

  task automatic test_e0_break();
    logic v[16];
    logic [7:0] d[16];
    logic l[16];
    int f;
    bit ok;
    expq.delete(); gotq.delete();
    tx_ready = 1'b1;
    evt_code = 9'h175; evt_make = 1'b0; evt_valid = 1'b1;
    tick();
    evt_valid = 1'b0;
    f = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      v[i] = s_valid; d[i] = s_data; l[i] = s_last;
      if (s_valid && f < 0) f = i;
    end
    checks++;
    if (f < 0 || f > 10) begin
      fails++; $display("FAIL e0_start: got first valid at %0d", f);
    end else begin
      checks++;
      if (!(v[f] && v[f+1] && v[f+2]) || v[f+3]) begin
        fails++;
        $display("FAIL e0_consecutive: got valid %b%b%b%b want 1110",
                 v[f], v[f+1], v[f+2], v[f+3]);
      end
      checks++;
      if ({d[f], d[f+1], d[f+2]} !== 24'hE0F075 ||
          {l[f], l[f+1], l[f+2]} !== 3'b001) begin
        fails++;
        $display("FAIL e0_bytes: got %h%h%h last %b%b%b want E0F075 last 001",
                 d[f], d[f+1], d[f+2], l[f], l[f+1], l[f+2]);
      end
    end
    drain(ok);
    checks++;
    if (gotq.size() != expq.size()) begin
      fails++;
      $display("FAIL e0_count: got %0d bytes want %0d",
               gotq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        fails++;
        $display("FAIL e0_byte%0d: got %h want %h", i, gotq[i], expq[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic pv, pr, pl;
    logic [7:0] pd;
    bit ok;
    expq.delete(); gotq.delete();
    tx_ready = 1'b1;
    evt_code = 9'h16B; evt_make = 1'b1; evt_valid = 1'b1;
    tick();
    evt_code = 9'h012; evt_make = 1'b0;
    tick();
    evt_valid = 1'b0;
    pv = 1'b0; pr = 1'b1; pd = 8'h00; pl = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tx_ready = (i % 2) == 1;
      tick();
      if (pv && !pr) begin
        checks++;
        if (!s_valid || s_data !== pd || s_last !== pl) begin
          fails++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b want 1 %h %b",
                   s_valid, s_data, s_last, pd, pl);
        end
      end
      pv = s_valid; pr = s_ready; pd = s_data; pl = s_last;
    end
    drain(ok);
    checks++;
    if (gotq.size() != 4 || expq.size() != 4) begin
      fails++;
      $display("FAIL stall_count: got %0d bytes, model %0d, want 4",
               gotq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        fails++;
        $display("FAIL stall_byte%0d: got %h want %h", i, gotq[i], expq[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic rdy[5];
    int pulses, pulse_at, lasts;
    bit ok, seen;
    expq.delete(); gotq.delete();
    tx_ready = 1'b0;
    evt_code = 9'h029; evt_make = 1'b1; evt_valid = 1'b1;
    tick();
    evt_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = s_valid;
    end
    checks++;
    if (!seen) begin
      fails++; $display("FAIL ovf_preload: got no tx_valid want 1");
    end
    pulses = 0; pulse_at = -1;
    for (int k = 0; k < 5; k++) begin
      evt_code = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 255))};
      evt_make = 1'($urandom_range(0, 1));
      evt_valid = 1'b1;
      tick();
      rdy[k] = s_evr;
      if (s_ovf) begin pulses++; pulse_at = k; end
    end
    evt_valid = 1'b0;
    for (int k = 5; k < 9; k++) begin
      tick();
      if (s_ovf) begin pulses++; pulse_at = k; end
    end
    checks++;
    if ({rdy[0], rdy[1], rdy[2], rdy[3], rdy[4]} !== 5'b11110) begin
      fails++;
      $display("FAIL ovf_ready: got %b%b%b%b%b want 11110",
               rdy[0], rdy[1], rdy[2], rdy[3], rdy[4]);
    end
    checks++;
    if (pulses != 1 || pulse_at != 5) begin
      fails++;
      $display("FAIL ovf_pulse: got %0d pulses at %0d want 1 at 5",
               pulses, pulse_at);
    end
    drain(ok);
    lasts = 0;
    foreach (gotq[i]) if (gotq[i][8]) lasts++;
    checks++;
    if (lasts != 5) begin
      fails++; $display("FAIL ovf_sequences: got %0d want 5", lasts);
    end
    checks++;
    if (gotq.size() != expq.size()) begin
      fails++;
      $display("FAIL ovf_count: got %0d bytes want %0d",
               gotq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        fails++;
        $display("FAIL ovf_byte%0d: got %h want %h", i, gotq[i], expq[i]);
      end
    end
  endtask

  task automatic test_gap();
    logic v[20], b[20], l[20];
    logic [7:0] d[20];
    int f;
    g_tx_ready = 1'b1;
    g_evt_code = 9'h05A; g_evt_make = 1'b0; g_evt_valid = 1'b1;
    tick();
    g_evt_valid = 1'b0;
    f = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      v[i] = gs_valid; b[i] = gs_busy; d[i] = gs_data; l[i] = gs_last;
      if (gs_valid && f < 0) f = i;
    end
    checks++;
    if (f < 0 || f > 10) begin
      fails++; $display("FAIL gap_start: got first valid at %0d", f);
    end else begin
      checks++;
      if (d[f] !== 8'hF0 || l[f] !== 1'b0) begin
        fails++; $display("FAIL gap_f0: got %h/%b want F0/0", d[f], l[f]);
      end
      checks++;
      if (v[f+1] || v[f+2] || v[f+3]) begin
        fails++;
        $display("FAIL gap_idle1: got valid %b%b%b want 000",
                 v[f+1], v[f+2], v[f+3]);
      end
      checks++;
      if (!v[f+4] || d[f+4] !== 8'h5A || !l[f+4]) begin
        fails++;
        $display("FAIL gap_code: got v=%b %h l=%b want 1 5A 1",
                 v[f+4], d[f+4], l[f+4]);
      end
      checks++;
      if (v[f+5] || v[f+6] || v[f+7] || !(b[f+5] && b[f+6] && b[f+7])) begin
        fails++;
        $display("FAIL gap_idle2: got valid %b%b%b busy %b%b%b want 000/111",
                 v[f+5], v[f+6], v[f+7], b[f+5], b[f+6], b[f+7]);
      end
      checks++;
      if (b[f+8] !== 1'b0) begin
        fails++; $display("FAIL gap_busy_end: got %b want 0", b[f+8]);
      end
    end
  endtask

  task automatic test_null();
    bit anyv, anyb, anyo;
    expq.delete(); gotq.delete();
    tx_ready = 1'b1;
    evt_code = 9'h000; evt_make = 1'b1; evt_valid = 1'b1;
    tick();
    checks++;
    if (s_evr !== 1'b1) begin
      fails++; $display("FAIL null_accept: got evt_ready=%b want 1", s_evr);
    end
    evt_valid = 1'b0;
    anyv = 1'b0; anyb = 1'b0; anyo = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      anyv |= s_valid; anyb |= s_busy; anyo |= s_ovf;
    end
    checks++;
    if (anyv || anyb) begin
      fails++; $display("FAIL null_quiet: got valid=%b busy=%b want 0/0",
                        anyv, anyb);
    end
    checks++;
    if (anyo) begin
      fails++; $display("FAIL null_overflow: got 1 want 0");
    end
  endtask

  task automatic test_random();
    logic pv, pr, pl;
    logic [7:0] pd;
    bit ok;
    expq.delete(); gotq.delete();
    pv = 1'b0; pr = 1'b1; pd = 8'h00; pl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      evt_valid = $urandom_range(0, 9) < 4;
      if ($urandom_range(0, 7) == 0)
        evt_code = 9'h000;
      else
        evt_code = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 255))};
      evt_make = 1'($urandom_range(0, 1));
      tx_ready = $urandom_range(0, 9) < 7;
      tick();
      if (pv && !pr) begin
        checks++;
        if (!s_valid || s_data !== pd || s_last !== pl) begin
          fails++;
          $display("FAIL rand_hold: got v=%b d=%h l=%b want 1 %h %b",
                   s_valid, s_data, s_last, pd, pl);
        end
      end
      pv = s_valid; pr = s_ready; pd = s_data; pl = s_last;
    end
    drain(ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL rand_drain: timeout, busy=%b", s_busy);
    end
    checks++;
    if (gotq.size() != expq.size()) begin
      fails++;
      $display("FAIL rand_count: got %0d bytes want %0d",
               gotq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        fails++;
        $display("FAIL rand_byte%0d: got %h want %h", i, gotq[i], expq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    expq.delete(); gotq.delete();
    tx_ready = 1'b0;
    evt_code = 9'h012; evt_make = 1'b0; evt_valid = 1'b1;
    tick();
    evt_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = s_valid;
    end
    checks++;
    if (!seen || s_data !== 8'hF0) begin
      fails++;
      $display("FAIL mid_f0: got valid=%b data=%h want 1 F0", seen, s_data);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || evt_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got valid=%b ready=%b busy=%b want 0 1 0",
               tx_valid, evt_ready, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    gotq.delete();
    tx_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (gotq.size() != 0) begin
      fails++;
      $display("FAIL mid_silent: got %0d bytes want 0", gotq.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    evt_valid = 1'b0; evt_make = 1'b0; evt_code = 9'h000; tx_ready = 1'b0;
    g_evt_valid = 1'b0; g_evt_make = 1'b0; g_evt_code = 9'h000;
    g_tx_ready = 1'b0;
    test_reset();
    test_single_make();
    test_e0_break();
    test_stall();
    test_overflow();
    test_gap();
    test_null();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
